// File: rtl/crack_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : crack_pkg
//  Description : Shared types and constants for the brute-force candidate
//                generator and match controller (state encoding, hash-core
//                port widths, charset defaults).
//  Revision    : 1.0 - initial release
// ============================================================================
package crack_pkg;

    localparam int HC_DATA_W = 256;                 // candidate bus width
    localparam int HC_LEN_W  = 64;                  // candidate length bus width
    localparam int LEN_W     = 6;                   // holds lengths 1..32
    localparam int MAX_CHARS = HC_DATA_W / 8;       // byte slots on the data bus

    localparam int         DEF_MAX_LEN  = 8;
    localparam logic [7:0] DEF_CH_BASE  = 8'h61;    // 'a'
    localparam int         DEF_CH_COUNT = 26;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        WAIT  = 3'd2,
        CHECK = 3'd3,
        DONE  = 3'd4
    } state_t;

endpackage
`default_nettype wire

// File: rtl/crack_ctrl_cand_counter.sv
`default_nettype none
// ============================================================================
//  Module      : cand_counter
//  Description : Odometer over a contiguous charset. Position 0 is the last
//                (rightmost, fastest) character. A carry out of the leftmost
//                used position grows the length by one with every character
//                at the charset base. 'last' flags that the next increment
//                would need a length beyond MAX_LEN.
//  Revision    : 1.0 - initial release
// ============================================================================
module cand_counter
    import crack_pkg::*;
#(
    parameter int         MAX_LEN  = DEF_MAX_LEN,
    parameter logic [7:0] CH_BASE  = DEF_CH_BASE,
    parameter int         CH_COUNT = DEF_CH_COUNT
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clear,
    input  logic                 inc,
    output logic [HC_DATA_W-1:0] data,
    output logic [LEN_W-1:0]     len,
    output logic                 last
);

    localparam logic [7:0] c_last_ch = 8'(int'(CH_BASE) + CH_COUNT - 1);

    logic [7:0]       r_chars [MAX_LEN];
    logic [LEN_W-1:0] r_len;
    logic [7:0]       w_next  [MAX_LEN];
    logic             w_carry;

    // Next odometer value; w_carry ends up set only when every used position wrapped
    always_comb begin
        w_carry = 1'b1;
        for (int i = 0; i < MAX_LEN; i++) begin
            w_next[i] = r_chars[i];
            if (LEN_W'(i) < r_len && w_carry) begin
                if (r_chars[i] == c_last_ch) begin
                    w_next[i] = CH_BASE;
                end else begin
                    w_next[i] = r_chars[i] + 8'd1;
                    w_carry   = 1'b0;
                end
            end
        end
    end

    assign last = w_carry && (r_len == LEN_W'(MAX_LEN));
    assign len  = r_len;

    // Candidate state: restart at a single base character, or step the odometer.
    // On a length carry w_next already holds all-base characters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < MAX_LEN; i++) r_chars[i] <= CH_BASE;
            r_len <= LEN_W'(1);
        end else if (clear) begin
            for (int i = 0; i < MAX_LEN; i++) r_chars[i] <= CH_BASE;
            r_len <= LEN_W'(1);
        end else if (inc && !last) begin
            r_chars <= w_next;
            if (w_carry) r_len <= r_len + LEN_W'(1);
        end
    end

    for (genvar g = 0; g < MAX_CHARS; g++) begin : g_data
        if (g < MAX_LEN) begin : g_used
            assign data[8*g +: 8] = (LEN_W'(g) < r_len) ? r_chars[g] : 8'h00;
        end else begin : g_unused
            assign data[8*g +: 8] = 8'h00;
        end
    end

endmodule
`default_nettype wire

// File: rtl/crack_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : crack_ctrl
//  Description : Brute-force candidate generator and match controller. Feeds
//                candidates to one hash core over a valid/ready handshake,
//                waits for the digest pulse, compares with the latched target
//                and reports the first match or exhaustion of the search.
//                Optional build macro CRACK_ATTEMPT_CNT_EN adds the 48-bit
//                'attempts' output counting CHECK cycles.
//  Revision    : 1.0 - initial release
// ============================================================================
module crack_ctrl
    import crack_pkg::*;
#(
    parameter int         MAX_LEN  = DEF_MAX_LEN,
    parameter logic [7:0] CH_BASE  = DEF_CH_BASE,
    parameter int         CH_COUNT = DEF_CH_COUNT,
    parameter int         DIGEST_W = 256
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 abort,
    input  logic [DIGEST_W-1:0]  target,
    output logic                 hc_valid,
    input  logic                 hc_ready,
    output logic [HC_DATA_W-1:0] hc_data,
    output logic [HC_LEN_W-1:0]  hc_len,
    input  logic                 hc_done,
    input  logic [DIGEST_W-1:0]  hc_digest,
    output logic                 busy,
    output logic                 found,
    output logic                 exhausted,
    output logic [HC_DATA_W-1:0] found_data,
    output logic [LEN_W-1:0]     found_len,
    output logic                 overflow_err
`ifdef CRACK_ATTEMPT_CNT_EN
    ,
    output logic [47:0]          attempts
`endif
);

    state_t               r_state;
    logic                 r_hc_valid;
    logic [DIGEST_W-1:0]  r_target;
    logic [DIGEST_W-1:0]  r_digest;
    logic                 r_found;
    logic                 r_exhausted;
    logic [HC_DATA_W-1:0] r_found_data;
    logic [LEN_W-1:0]     r_found_len;
    logic                 r_overflow;

    logic [HC_DATA_W-1:0] w_cand_data;
    logic [LEN_W-1:0]     w_cand_len;
    logic                 w_cand_last;
    logic                 w_match;
    logic                 w_accept_start;
    logic                 w_cnt_inc;

    assign w_match        = (r_digest == r_target);
    // start is honoured only from IDLE/DONE and always loses to abort
    assign w_accept_start = start && !abort && (r_state == IDLE || r_state == DONE);
    assign w_cnt_inc      = !abort && (r_state == CHECK) && !w_match;

    cand_counter #(
        .MAX_LEN  (MAX_LEN),
        .CH_BASE  (CH_BASE),
        .CH_COUNT (CH_COUNT)
    ) u_cand (
        .clk   (clk),
        .reset (reset),
        .clear (w_accept_start),
        .inc   (w_cnt_inc),
        .data  (w_cand_data),
        .len   (w_cand_len),
        .last  (w_cand_last)
    );

    // Controller FSM: handshake sequencing, target/digest capture, match and exhaustion flags
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= IDLE;
            r_hc_valid   <= 1'b0;
            r_target     <= '0;
            r_digest     <= '0;
            r_found      <= 1'b0;
            r_exhausted  <= 1'b0;
            r_found_data <= '0;
            r_found_len  <= '0;
            r_overflow   <= 1'b0;
        end else begin
            r_overflow <= 1'b0;
            if (abort) begin
                r_state      <= IDLE;
                r_hc_valid   <= 1'b0;
                r_found      <= 1'b0;
                r_exhausted  <= 1'b0;
                r_found_data <= '0;
                r_found_len  <= '0;
            end else begin
                case (r_state)
                    IDLE, DONE: begin
                        if (start) begin
                            r_state      <= ISSUE;
                            r_hc_valid   <= 1'b1;
                            r_target     <= target;
                            r_found      <= 1'b0;
                            r_exhausted  <= 1'b0;
                            r_found_data <= '0;
                            r_found_len  <= '0;
                        end
                    end
                    ISSUE: begin
                        if (hc_ready) begin
                            r_hc_valid <= 1'b0;
                            r_state    <= WAIT;
                        end
                    end
                    WAIT: begin
                        if (hc_done) begin
                            r_digest <= hc_digest;
                            r_state  <= CHECK;
                        end
                    end
                    CHECK: begin
                        if (w_match) begin
                            r_found      <= 1'b1;
                            r_found_data <= w_cand_data;
                            r_found_len  <= w_cand_len;
                            r_state      <= DONE;
                        end else if (w_cand_last) begin
                            r_overflow  <= 1'b1;
                            r_exhausted <= 1'b1;
                            r_state     <= DONE;
                        end else begin
                            r_hc_valid <= 1'b1;
                            r_state    <= ISSUE;
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    // Candidate bus reads zero whenever no candidate is being offered
    assign hc_valid     = r_hc_valid;
    assign hc_data      = r_hc_valid ? w_cand_data : '0;
    assign hc_len       = r_hc_valid ? HC_LEN_W'(w_cand_len) : '0;
    assign busy         = (r_state == ISSUE) || (r_state == WAIT) || (r_state == CHECK);
    assign found        = r_found;
    assign exhausted    = r_exhausted;
    assign found_data   = r_found_data;
    assign found_len    = r_found_len;
    assign overflow_err = r_overflow;

`ifdef CRACK_ATTEMPT_CNT_EN
    logic [47:0] r_attempts;

    // One count per compare; restarts with each accepted start
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_attempts <= '0;
        end else if (w_accept_start) begin
            r_attempts <= '0;
        end else if (!abort && r_state == CHECK) begin
            r_attempts <= r_attempts + 48'd1;
        end
    end

    assign attempts = r_attempts;
`endif

endmodule
`default_nettype wire

// File: tb/tb_crack_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_crack_ctrl
//  Description : Directed bench for crack_ctrl. A behavioural hash core either
//                returns the zero-extended candidate (identity mode) or its
//                real SHA-256 digest. A second instance with MAX_LEN=2 and
//                CH_COUNT=3 covers search exhaustion.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_crack_ctrl;

    localparam int M_ID  = 0;
    localparam int M_SHA = 1;

    localparam logic [31:0] SHA_K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };
    localparam logic [31:0] SHA_H0 [8] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };
    localparam logic [255:0] ABC_DIGEST =
        256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;

    logic clk = 1'b0;
    logic reset;
    logic start_d, start_s, abort;
    logic [255:0] target;
    logic hc_ready, hc_done;
    logic [255:0] hc_digest;

    logic         hc_valid_d, busy_d, found_d, exhausted_d, overflow_d;
    logic [255:0] hc_data_d, found_data_d;
    logic [63:0]  hc_len_d;
    logic [5:0]   found_len_d;
    logic         hc_valid_s, busy_s, found_s, exhausted_s, overflow_s;
    logic [255:0] hc_data_s, found_data_s;
    logic [63:0]  hc_len_s;
    logic [5:0]   found_len_s;
`ifdef CRACK_ATTEMPT_CNT_EN
    logic [47:0]  attempts_d, attempts_s;
`endif

    // Bench state shared between the sequencer and the hash-core model
    int           n_chk = 0;
    int           n_pass = 0;
    bit           sel = 1'b0;       // 0: default instance, 1: small instance
    int           mode = M_ID;
    int           lat = 2;
    int           cur_count = 26;
    int           stall_req = 0;
    int           n_stall = 0;
    int           n_xfer = 0;
    int           n_ovf = 0;
    logic [255:0] first_data [4];
    logic [255:0] data27;
    logic [255:0] last_data;
    logic [63:0]  last_len;
    logic [255:0] snap_data;
    logic [63:0]  snap_len;

    logic         m_valid;
    logic [255:0] m_data;
    logic [63:0]  m_len;
    assign m_valid = sel ? hc_valid_s : hc_valid_d;
    assign m_data  = sel ? hc_data_s  : hc_data_d;
    assign m_len   = sel ? hc_len_s   : hc_len_d;

    always #5 clk = ~clk;

    crack_ctrl u_dut (
        .clk(clk), .reset(reset), .start(start_d), .abort(abort), .target(target),
        .hc_valid(hc_valid_d), .hc_ready(hc_ready), .hc_data(hc_data_d), .hc_len(hc_len_d),
        .hc_done(hc_done), .hc_digest(hc_digest), .busy(busy_d), .found(found_d),
        .exhausted(exhausted_d), .found_data(found_data_d), .found_len(found_len_d),
        .overflow_err(overflow_d)
`ifdef CRACK_ATTEMPT_CNT_EN
        , .attempts(attempts_d)
`endif
    );

    crack_ctrl #(.MAX_LEN(2), .CH_COUNT(3)) u_dut_s (
        .clk(clk), .reset(reset), .start(start_s), .abort(abort), .target(target),
        .hc_valid(hc_valid_s), .hc_ready(hc_ready), .hc_data(hc_data_s), .hc_len(hc_len_s),
        .hc_done(hc_done), .hc_digest(hc_digest), .busy(busy_s), .found(found_s),
        .exhausted(exhausted_s), .found_data(found_data_s), .found_len(found_len_s),
        .overflow_err(overflow_s)
`ifdef CRACK_ATTEMPT_CNT_EN
        , .attempts(attempts_s)
`endif
    );

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [31:0] ror(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // Single-block SHA-256 of a right-aligned message of len bytes (len <= 32)
    function automatic logic [255:0] sha256(input logic [255:0] d, input int len);
        logic [511:0] blk;
        logic [31:0]  w [64];
        logic [31:0]  a, b, c, dd, e, f, g, h, t1, t2;
        blk = '0;
        for (int i = 0; i < len; i++) blk[511-8*i -: 8] = d[8*(len-1-i) +: 8];
        blk[511-8*len -: 8] = 8'h80;
        blk[63:0] = 64'(len) << 3;
        for (int i = 0; i < 16; i++) w[i] = blk[511-32*i -: 32];
        for (int i = 16; i < 64; i++)
            w[i] = (ror(w[i-2], 17) ^ ror(w[i-2], 19) ^ (w[i-2] >> 10)) + w[i-7]
                 + (ror(w[i-15], 7) ^ ror(w[i-15], 18) ^ (w[i-15] >> 3)) + w[i-16];
        a = SHA_H0[0]; b = SHA_H0[1]; c = SHA_H0[2]; dd = SHA_H0[3];
        e = SHA_H0[4]; f = SHA_H0[5]; g = SHA_H0[6]; h = SHA_H0[7];
        for (int i = 0; i < 64; i++) begin
            t1 = h + (ror(e, 6) ^ ror(e, 11) ^ ror(e, 25)) + ((e & f) ^ (~e & g)) + SHA_K[i] + w[i];
            t2 = (ror(a, 2) ^ ror(a, 13) ^ ror(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
            h = g; g = f; f = e; e = dd + t1; dd = c; c = b; b = a; a = t1 + t2;
        end
        return {SHA_H0[0] + a, SHA_H0[1] + b, SHA_H0[2] + c, SHA_H0[3] + dd,
                SHA_H0[4] + e, SHA_H0[5] + f, SHA_H0[6] + g, SHA_H0[7] + h};
    endfunction

    // Expected idx-th candidate (0-based): skip whole length classes, then base-cnt digits
    function automatic logic [255:0] exp_cand(input int idx, input int cnt, output int len);
        int n = idx;
        int p = cnt;
        int l = 1;
        logic [255:0] d = '0;
        while (n >= p) begin
            n -= p;
            p *= cnt;
            l++;
        end
        for (int i = 0; i < l; i++) begin
            d[8*i +: 8] = 8'(32'h61 + n % cnt);
            n = n / cnt;
        end
        len = l;
        return d;
    endfunction

    // Behavioural hash core, driven on the falling edge
    initial begin
        bit           pend = 1'b0;
        int           lat_left = 0;
        logic [255:0] pend_dig = '0;
        hc_ready = 1'b1; hc_done = 1'b0; hc_digest = '0;
        forever begin
            @(negedge clk);
            hc_done = 1'b0;
            if (pend) begin
                if (lat_left == 0) begin
                    hc_done   = 1'b1;
                    hc_digest = pend_dig;
                    pend      = 1'b0;
                end else begin
                    lat_left--;
                end
            end
            if (m_valid && stall_req > 0) begin
                hc_ready = 1'b0;
                if (n_stall == 0) begin
                    snap_data = m_data;
                    snap_len  = m_len;
                end else begin
                    chk("bp_data_stable", m_data, snap_data);
                    chk("bp_len_stable", 256'(m_len), 256'(snap_len));
                end
                stall_req--;
                n_stall++;
            end else begin
                hc_ready = 1'b1;
                if (m_valid) begin
                    int           elen;
                    logic [255:0] edata;
                    edata = exp_cand(n_xfer, cur_count, elen);
                    chk("seq_data", m_data, edata);
                    chk("seq_len", 256'(m_len), 256'(elen));
                    chk("xfer_overlap", 256'(pend), 256'(0));
                    if (n_xfer < 4) first_data[n_xfer] = m_data;
                    if (n_xfer == 26) data27 = m_data;
                    last_data = m_data;
                    last_len  = m_len;
                    n_xfer++;
                    pend      = 1'b1;
                    lat_left  = lat;
                    pend_dig  = (mode == M_SHA) ? sha256(m_data, int'(m_len)) : m_data;
                end
            end
        end
    end

    // Overflow pulse counter for the small instance
    initial begin
        forever begin
            @(negedge clk);
            if (overflow_s) n_ovf++;
        end
    end

    task automatic pulse_start();
        @(negedge clk);
        if (sel) start_s = 1'b1; else start_d = 1'b1;
        @(negedge clk);
        start_s = 1'b0; start_d = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n = 0;
        while (!(sel ? (found_s | exhausted_s) : (found_d | exhausted_d)) && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (n >= budget) begin
            n_chk++;
            $display("FAIL %s: no found/exhausted after %0d cycles, required completion", tag, budget);
        end
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached, required $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; start_d = 1'b0; start_s = 1'b0; abort = 1'b0; target = '0;
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_flags", 256'({hc_valid_d, busy_d, found_d, exhausted_d, overflow_d}), 256'(0));
        chk("rst_data", hc_data_d, 256'(0));
        chk("rst_len", 256'(hc_len_d), 256'(0));
        chk("rst_found", found_data_d | 256'(found_len_d), 256'(0));
        @(negedge clk);
        reset = 1'b0;

        // Order and wrap in identity mode; "ba" is candidate 26 + 26 + 1 = 53
        sel = 1'b0; mode = M_ID; cur_count = 26; n_xfer = 0; lat = 2;
        target = 256'h6261;
        pulse_start();
        repeat (10) @(negedge clk);
        target = 256'h61;          // start while busy must be ignored
        pulse_start();
        wait_done("order", 3000);
        chk("ord_c0", first_data[0], 256'h61);
        chk("ord_c1", first_data[1], 256'h62);
        chk("ord_c2", first_data[2], 256'h63);
        chk("ord_c3", first_data[3], 256'h64);
        chk("ord_c27_aa", data27, 256'h6161);
        chk("ord_found", 256'({found_d, exhausted_d, busy_d}), 256'(3'b100));
        chk("ord_fdata", found_data_d, 256'h6261);
        chk("ord_flen", 256'(found_len_d), 256'(2));
        chk("ord_xfers", 256'(n_xfer), 256'(53));
`ifdef CRACK_ATTEMPT_CNT_EN
        chk("ord_attempts", 256'(attempts_d), 256'(53));
`endif

        // Backpressure on the first candidate, restart from DONE; "c" is the 3rd candidate
        n_xfer = 0; n_stall = 0; stall_req = 5;
        target = 256'h63;
        pulse_start();
        wait_done("backpressure", 500);
        chk("bp_stalls", 256'(n_stall), 256'(5));
        chk("bp_xfers", 256'(n_xfer), 256'(3));
        chk("bp_fdata", found_data_d, 256'h63);

        // Abort in WAIT followed by a stray digest pulse
        n_xfer = 0; lat = 12; target = '1;
        pulse_start();
        for (int i = 0; i < 20 && n_xfer == 0; i++) @(negedge clk);
        repeat (3) @(negedge clk);
        chk("ab_in_wait", 256'({busy_d, hc_valid_d}), 256'(2'b10));
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("ab_idle", 256'({busy_d, hc_valid_d, found_d, exhausted_d}), 256'(0));
        repeat (16) @(negedge clk);
        chk("ab_stray", 256'({busy_d, found_d, hc_valid_d}), 256'(0));
        chk("ab_xfers", 256'(n_xfer), 256'(1));
`ifdef CRACK_ATTEMPT_CNT_EN
        chk("ab_attempts", 256'(attempts_d), 256'(0));
`endif
        n_xfer = 0; lat = 2; target = 256'h61;
        pulse_start();
        wait_done("restart", 200);
        chk("rs_first", first_data[0], 256'h61);
        chk("rs_xfers", 256'(n_xfer), 256'(1));
        chk("rs_fdata", found_data_d | 256'({found_len_d, 8'h00}), 256'h161);

        // Real SHA-256 of "abc": 26 + 676 + 29 = 731 candidates
        mode = M_SHA; n_xfer = 0; target = ABC_DIGEST;
        pulse_start();
        wait_done("abc", 8000);
        chk("abc_found", 256'({found_d, exhausted_d}), 256'(2'b10));
        chk("abc_fdata", found_data_d, 256'h616263);
        chk("abc_flen", 256'(found_len_d), 256'(3));
        chk("abc_xfers", 256'(n_xfer), 256'(731));
`ifdef CRACK_ATTEMPT_CNT_EN
        chk("abc_attempts", 256'(attempts_d), 256'(731));
`endif

        // Exhaustion on the small instance: 3 + 9 = 12 candidates, last "cc"
        sel = 1'b1; mode = M_ID; cur_count = 3; n_xfer = 0; n_ovf = 0; target = '1;
        pulse_start();
        wait_done("exhaust", 500);
        repeat (2) @(negedge clk);
        chk("ex_flags", 256'({exhausted_s, found_s, busy_s}), 256'(3'b100));
        chk("ex_xfers", 256'(n_xfer), 256'(12));
        chk("ex_last", last_data, 256'h6363);
        chk("ex_last_len", 256'(last_len), 256'(2));
        chk("ex_ovf", 256'(n_ovf), 256'(1));
`ifdef CRACK_ATTEMPT_CNT_EN
        chk("ex_attempts", 256'(attempts_s), 256'(12));
`endif

        // Asynchronous reset in the middle of a search
        sel = 1'b0; cur_count = 26; n_xfer = 0; target = '1;
        pulse_start();
        repeat (20) @(negedge clk);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("ar_flags_d", 256'({hc_valid_d, busy_d, found_d, exhausted_d}), 256'(0));
        chk("ar_data_d", hc_data_d | 256'(hc_len_d), 256'(0));
        chk("ar_flags_s", 256'({exhausted_s, found_s, busy_s}), 256'(0));
        @(negedge clk);
        reset = 1'b0;
        repeat (20) @(negedge clk);
        chk("ar_stays_idle", 256'({busy_d, hc_valid_d, found_d}), 256'(0));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
